mult_flux_sched: RTL

Round-robin, context-aware flux scheduler for the multi-flux tagged actors in the HEVC dataflow (the 18×9 coefficient multiplier first). It holds one flux tag for the shared datapath for a whole coefficient block. It releases the tag on block end, on starvation of the owner, or, optionally, after a burst budget, so that no flux monopolises the datapath. The actor keeps per-flux context, so a release mid-block is always safe. This block owns only the decision of which tag the datapath serves.

---
 rtl/mult_flux_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mult_flux_sched.sv
// Round-robin flux scheduler: holds one flux tag on the shared datapath per coefficient block.
// Optional burst-budget yield is compiled in with `define MULT_FLUX_SCHED_BURST_EN.
module mult_flux_sched #(
   parameter  int FLUX        = 2,
   parameter  int HOLD_CYCLES = 2,
   parameter  int MAX_BURST   = 8,
   localparam int TAG_WIDTH   = $clog2(FLUX)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [FLUX-1:0]      req,
   input  logic                 fire,
   input  logic                 last,
   output logic                 gnt_valid,
   output logic [TAG_WIDTH-1:0] gnt_tag,
   output logic [FLUX-1:0]      gnt_onehot,
   output logic                 err
);

   localparam int                   IDLE_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [TAG_WIDTH-1:0] LAST_TAG  = TAG_WIDTH'(FLUX - 1);
   localparam logic [IDLE_W-1:0]    HOLD_LAST = IDLE_W'(HOLD_CYCLES - 1);

   if (FLUX < 2 || HOLD_CYCLES < 1 || MAX_BURST < 1) begin : g_bad_param
      $error("mult_flux_sched: FLUX>=2, HOLD_CYCLES>=1, MAX_BURST>=1 required");
   end

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t               r_state;
   logic [TAG_WIDTH-1:0] r_ptr;
   logic [TAG_WIDTH-1:0] r_tag;
   logic [FLUX-1:0]      r_onehot;
   logic                 r_valid;
   logic                 r_err;
   logic [IDLE_W-1:0]    r_idle;

   logic [TAG_WIDTH-1:0] w_rel_ptr;
   logic [TAG_WIDTH-1:0] w_arb_ptr;
   logic [TAG_WIDTH-1:0] w_idx;
   logic [TAG_WIDTH-1:0] w_win_tag;
   logic [FLUX-1:0]      w_win_oh;
   logic                 w_win;
   logic                 w_own_req;
   logic                 w_idle_hit;
   logic                 w_burst_hit;
   logic                 w_release;

   // While owning, the search starts just past the current owner so a release
   // arbitrates with the post-release pointer in the same cycle.
   always_comb begin
      w_rel_ptr = (r_tag == LAST_TAG) ? '0 : r_tag + 1'b1;
      w_arb_ptr = (r_state == S_OWN) ? w_rel_ptr : r_ptr;
      w_idx     = '0;
      w_win     = 1'b0;
      w_win_tag = '0;
      for (int k = FLUX - 1; k >= 0; k--) begin
         w_idx = (int'(w_arb_ptr) + k >= FLUX) ? TAG_WIDTH'(int'(w_arb_ptr) + k - FLUX)
                                              : TAG_WIDTH'(int'(w_arb_ptr) + k);
         if (req[w_idx]) begin
            w_win     = 1'b1;
            w_win_tag = w_idx;
         end
      end
      w_win_oh = FLUX'(1) << w_win_tag;
   end

   assign w_own_req  = req[r_tag];
   assign w_idle_hit = !w_own_req && (r_idle == HOLD_LAST);
   assign w_release  = (r_state == S_OWN) && ((fire && last) || w_idle_hit || w_burst_hit);

`ifdef MULT_FLUX_SCHED_BURST_EN
   localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

   logic [BURST_W-1:0] r_burst;
   logic [BURST_W-1:0] w_burst_nxt;

   // Count includes this cycle's fire, so the yield lands on the budget-reaching edge.
   assign w_burst_nxt = (fire && r_burst != BURST_MAX) ? r_burst + 1'b1 : r_burst;
   assign w_burst_hit = (w_burst_nxt == BURST_MAX) && |(req & ~r_onehot);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               r_burst <= '0;
      else if (r_state == S_OWN && !w_release) r_burst <= w_burst_nxt;
      else                                    r_burst <= '0;
   end
`else
   assign w_burst_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_tag    <= '0;
         r_onehot <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_idle   <= '0;
      end else begin
         if (fire && !r_valid) r_err <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_win) begin
                  r_state  <= S_OWN;
                  r_valid  <= 1'b1;
                  r_tag    <= w_win_tag;
                  r_onehot <= w_win_oh;
                  r_idle   <= '0;
               end
            end
            S_OWN: begin
               if (w_release) begin
                  r_ptr  <= w_rel_ptr;
                  r_idle <= '0;
                  if (w_win) begin
                     r_tag    <= w_win_tag;
                     r_onehot <= w_win_oh;
                  end else begin
                     r_state  <= S_IDLE;
                     r_valid  <= 1'b0;
                     r_tag    <= '0;
                     r_onehot <= '0;
                  end
               end else begin
                  r_idle <= w_own_req ? '0 : r_idle + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt_valid  = r_valid;
   assign gnt_tag    = r_tag;
   assign gnt_onehot = r_onehot;
   assign err        = r_err;

endmodule
